// File: rtl/tff_pkg.sv
// Shared constants for the T-flip-flop counter: legal width range and default end-of-range policy.
package tff_pkg;
    localparam int unsigned TFF_WIDTH_MIN    = 2;
    localparam int unsigned TFF_WIDTH_MAX    = 32;
    localparam bit          TFF_WRAP_DEFAULT = 1'b1;
endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop bit with synchronous clear/load; priority sclr > sload > toggle.
// Latency: one edge. No backpressure; acts on every rising clk edge.
module tff_cell (
    input  logic clk,
    input  logic reset_n,
    input  logic sclr,
    input  logic sload,
    input  logic d,
    input  logic t,
    output logic q
);
    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (sclr) begin
            q_d = 1'b0;
        end else if (sload) begin
            q_d = d;
        end else if (t) begin
            q_d = ~q_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/tff_counter.sv
// Up (or up/down with TFF_COUNTER_DOWN_EN) counter built from per-bit T cells; wrap or saturate.
// Latency: q and ovf update one edge after the request; tc is combinational from q.
// No backpressure: a request with en=1 and t=1 is taken on every edge.
module tff_counter
    import tff_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter bit          WRAP  = TFF_WRAP_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             t,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef TFF_COUNTER_DOWN_EN
    input  logic             up_dn,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);
    if (WIDTH < TFF_WIDTH_MIN || WIDTH > TFF_WIDTH_MAX) begin : g_width_check
        $error("tff_counter: WIDTH out of range");
    end

    logic             count_up;
    logic             cnt_act;
    logic             at_tc;
    logic             step;
    logic [WIDTH-1:0] ones_below;
    logic [WIDTH-1:0] zeros_below;
    logic [WIDTH-1:0] tog;
    logic             ovf_q;
    logic             ovf_d;

`ifdef TFF_COUNTER_DOWN_EN
    assign count_up = up_dn;
`else
    assign count_up = 1'b1;
`endif

    assign cnt_act = en & t & ~clr & ~load;
    assign at_tc   = count_up ? (&q) : ~(|q);
    // Saturate mode suppresses every toggle at terminal count; wrap falls out of the carry chain.
    assign step    = cnt_act & (WRAP | ~at_tc);

    always_comb begin
        ones_below     = '0;
        zeros_below    = '0;
        ones_below[0]  = 1'b1;
        zeros_below[0] = 1'b1;
        for (int i = 1; i < int'(WIDTH); i++) begin
            ones_below[i]  = ones_below[i-1] & q[i-1];
            zeros_below[i] = zeros_below[i-1] & ~q[i-1];
        end
        tog = {WIDTH{step}} & (count_up ? ones_below : zeros_below);
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        tff_cell u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .sclr    (clr),
            .sload   (load),
            .d       (load_val[i]),
            .t       (tog[i]),
            .q       (q[i])
        );
    end

    assign ovf_d = cnt_act & at_tc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign tc  = at_tc;
    assign ovf = ovf_q;
endmodule

// File: doc/tff_counter.md
TFF_COUNTER -- requirements
Module: tff_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 SHALL have parameter WRAP, default 1: 1 = wrap at terminal count, 0 = saturate at terminal count.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  count enable; gates t only.
REQ-006 SHALL have port t  input  1  count request; acts only when en=1.
REQ-007 SHALL have port clr  input  1  synchronous clear.
REQ-008 SHALL have port load  input  1  synchronous parallel load.
REQ-009 SHALL have port load_val  input  WIDTH  value loaded when load=1.
REQ-010 SHALL have port up_dn  input  1  direction, 1 = up, 0 = down; present only with TFF_COUNTER_DOWN_EN.
REQ-011 SHALL have port q  output  WIDTH  registered count.
REQ-012 SHALL have port tc  output  1  combinational terminal-count flag.
REQ-013 SHALL have port ovf  output  1  registered one-cycle overflow/underflow pulse.

Function
REQ-014 SHALL apply per-edge priority clr > load > count > hold.
REQ-015 SHALL, when clr=1, set q to 0 on the next edge, whatever the state of load, en and t.
REQ-016 SHALL, when load=1 and clr=0, set q to load_val on the next edge, whatever the state of en and t.
REQ-017 SHALL count only when en=1 and t=1, with clr=0 and load=0; otherwise q holds.
REQ-018 SHALL build the count from per-bit T cells:
- Counting up, bit i toggles when the request is active and bits 0..i-1 are all 1.
- Counting down, bit i toggles when the request is active and bits 0..i-1 are all 0.
REQ-019 SHALL change q by exactly one step per count cycle, with a latency of one clock edge.
REQ-020 SHALL define terminal count as q = all ones when counting up and q = 0 when counting down.
REQ-021 SHALL drive tc = 1 exactly when q is at terminal count for the current direction.
REQ-022 SHALL, when counting at terminal count with WRAP=1, wrap q (all ones to 0 up; 0 to all ones down).
REQ-023 SHALL, when counting at terminal count with WRAP=0, hold q unchanged.
REQ-024 SHALL assert ovf for exactly one cycle after each edge on which a count occurred at terminal count, in both WRAP modes.
REQ-025 SHALL hold ovf at 0 after every other edge, including clr and load edges.
REQ-026 SHALL produce back-to-back ovf pulses when counting continues at terminal count in saturate mode.

Reset
REQ-027 SHALL, while reset_n=0, force q = 0 and ovf = 0 asynchronously, independent of clk.
REQ-028 SHALL, in reset, give tc = 1 when counting down (q = 0) and tc = 0 when counting up.
REQ-029 SHALL treat reset asserted mid-count as abandoning the pending update.
REQ-030 SHALL apply the first count, load or clear on the first rising clk edge after reset_n deasserts.

Configuration
REQ-031 SHALL use macro TFF_COUNTER_DOWN_EN to compile the up_dn port and down-count logic in or out.
REQ-032 SHALL, without TFF_COUNTER_DOWN_EN, count up only, with tc = &q and no up_dn port.
REQ-033 SHALL, with TFF_COUNTER_DOWN_EN, take direction from up_dn as sampled on each edge; a direction change takes effect on that edge.

Structure
REQ-034 SHALL place WIDTH limits and the default WRAP constant in shared package tff_pkg.
REQ-035 SHALL instantiate sub-module tff_cell per bit.
REQ-036 SHALL give tff_cell ports clk, reset_n, sclr, sload, d, t, q, where it is a clocked T flip-flop with async active-low reset and priority sclr > sload > toggle.
REQ-037 SHALL generate the per-bit toggle chain combinationally in tff_counter.

Verification
REQ-038 SHALL cover reset: WIDTH=4; hold reset_n=0 for 10 ns with t=1, en=1 -> q=0 and ovf=0 throughout; first count after release -> q=1.
REQ-039 SHALL cover up wrap: WIDTH=4, WRAP=1; load 4'hE, then count 3 cycles -> q=F (tc=1), then 0 (ovf=1 for one cycle), then 1.
REQ-040 SHALL cover saturate: WIDTH=4, WRAP=0; load 4'hF, count 3 cycles -> q stays F, tc=1, ovf=1 on three consecutive cycles.
REQ-041 SHALL cover hold: en=0, t=1 toggling for 5 cycles -> q unchanged; with en=1, t=0 -> q unchanged.
REQ-042 SHALL cover priority: clr=1, load=1 (load_val=4'h9), en=1, t=1 on one edge -> q=0, ovf=0; load=1 alone with t=1 -> q=9.
REQ-043 SHALL cover down count with TFF_COUNTER_DOWN_EN: up_dn=0, q=1, count 2 cycles -> q=0 (tc=1), then F with ovf=1 (WRAP=1).
